// File: rtl/tail_light_sequencer.sv
// Rear-lamp sequencer: prioritised hazard/turn arbitration, prescaled three-step
// turn sweep and hazard blink, with a brake overlay on registered lamp outputs.
module tail_light_sequencer #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic left_req_i,
  input  logic right_req_i,
  input  logic hazard_req_i,
  input  logic brake_i,
  output logic la_o,
  output logic lb_o,
  output logic lc_o,
  output logic ra_o,
  output logic rb_o,
  output logic rc_o,
  output logic busy_o,
  output logic step_o
);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, HZ_ON, HZ_OFF
  } state_t;

  localparam logic [7:0] LastCnt = 8'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  lamps_q, lamps_d;
  logic        tick;
  logic        in_turn;

  // Lamp order is {la, lb, lc, ra, rb, rc}; brake lights the side not in use.
  function automatic logic [5:0] pattern(input state_t s, input logic brake);
    logic [5:0] p;
    p = 6'b000000;
    unique case (s)
      IDLE:    p = brake ? 6'b111111 : 6'b000000;
      L1:      p = brake ? 6'b100111 : 6'b100000;
      L2:      p = brake ? 6'b110111 : 6'b110000;
      L3:      p = brake ? 6'b111111 : 6'b111000;
      R1:      p = brake ? 6'b111100 : 6'b000100;
      R2:      p = brake ? 6'b111110 : 6'b000110;
      R3:      p = brake ? 6'b111111 : 6'b000111;
      HZ_ON:   p = 6'b111111;
      HZ_OFF:  p = 6'b000000;
      default: p = 6'b000000;
    endcase
    return p;
  endfunction

  assign tick    = (state_q != IDLE) && (cnt_q == LastCnt);
  assign in_turn = (state_q == L1) || (state_q == L2) || (state_q == L3) ||
                   (state_q == R1) || (state_q == R2) || (state_q == R3);

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    if (state_q != IDLE && !tick) begin
      cnt_d = 8'(cnt_q + 8'd1);
    end
    unique case (state_q)
      IDLE: begin
        if (hazard_req_i || (left_req_i && right_req_i)) state_d = HZ_ON;
        else if (left_req_i)                             state_d = L1;
        else if (right_req_i)                            state_d = R1;
      end
      L1:     if (tick) state_d = L2;
      L2:     if (tick) state_d = L3;
      L3:     if (tick) state_d = IDLE;
      R1:     if (tick) state_d = R2;
      R2:     if (tick) state_d = R3;
      R3:     if (tick) state_d = IDLE;
      HZ_ON:  if (tick) state_d = HZ_OFF;
      HZ_OFF: if (tick) state_d = hazard_req_i ? HZ_ON : IDLE;
      default: state_d = IDLE;
    endcase
    // Hazard preempts any sweep immediately and restarts the blink timing.
    if (in_turn && hazard_req_i) begin
      state_d = HZ_ON;
      cnt_d   = 8'd0;
    end
    lamps_d = pattern(state_d, brake_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      lamps_q <= 6'b000000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_d;
    end
  end

  assign {la_o, lb_o, lc_o, ra_o, rb_o, rc_o} = lamps_q;
  assign busy_o = (state_q != IDLE);
  assign step_o = tick;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Scoreboard bench for tail_light_sequencer: per-cycle expected {lamps,busy,step}
// are queued per scenario and popped after every rising edge.
module tb_tail_light_sequencer;

  typedef struct packed {
    logic [5:0] lamps;
    logic       busy;
    logic       step;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0;
  logic left1 = 1'b0;
  logic la, lb, lc, ra, rb, rc, busy, step;
  logic la1, lb1, lc1, ra1, rb1, rc1, busy1, step1;

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [7:0] obs;

  always #5 clk = ~clk;

  tail_light_sequencer #(.TICK_DIV(4)) dut (
    .clk_i(clk), .reset_i(reset), .left_req_i(left), .right_req_i(right),
    .hazard_req_i(hazard), .brake_i(brake),
    .la_o(la), .lb_o(lb), .lc_o(lc), .ra_o(ra), .rb_o(rb), .rc_o(rc),
    .busy_o(busy), .step_o(step));

  tail_light_sequencer #(.TICK_DIV(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .left_req_i(left1), .right_req_i(1'b0),
    .hazard_req_i(1'b0), .brake_i(1'b0),
    .la_o(la1), .lb_o(lb1), .lc_o(lc1), .ra_o(ra1), .rb_o(rb1), .rc_o(rc1),
    .busy_o(busy1), .step_o(step1));

  task automatic applyStimulus(input logic l, input logic r, input logic h,
                               input logic b, input logic rst);
    left = l; right = r; hazard = h; brake = b; reset = rst;
  endtask

  // step is expected only on the final cycle of a state that runs to its tick.
  task automatic push_seg(input logic [5:0] l, input logic b, input int n, input bit full);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      x.lamps = l;
      x.busy  = b;
      x.step  = b && full && (i == n - 1);
      exp_q.push_back(x);
    end
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    obs = {la, lb, lc, ra, rb, rc, busy, step};
    checks++;
    if (obs !== 8'b0) $display("[TB] FAIL reset: got %b want %b", obs, 8'b0);
    else passed++;
    obs = {la1, lb1, lc1, ra1, rb1, rc1, busy1, step1};
    checks++;
    if (obs !== 8'b0) $display("[TB] FAIL reset_div1: got %b want %b", obs, 8'b0);
    else passed++;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_left_pulse();
    push_seg(6'b100000, 1'b1, 4, 1'b1);
    push_seg(6'b110000, 1'b1, 4, 1'b1);
    push_seg(6'b111000, 1'b1, 4, 1'b1);
    push_seg(6'b000000, 1'b0, 1, 1'b0);
    for (int c = 0; c < 13; c++) begin
      applyStimulus(c == 0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la, lb, lc, ra, rb, rc, busy, step};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL left_pulse c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
  endtask

  task automatic test_brake_right();
    push_seg(6'b111111, 1'b0, 1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      push_seg(6'b111100, 1'b1, 4, 1'b1);
      push_seg(6'b111110, 1'b1, 4, 1'b1);
      push_seg(6'b111111, 1'b1, 4, 1'b1);
      push_seg(k == 0 ? 6'b111111 : 6'b000000, 1'b0, 1, 1'b0);
    end
    for (int c = 0; c < 27; c++) begin
      applyStimulus(1'b0, (c >= 1 && c <= 14), 1'b0, (c <= 25), 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la, lb, lc, ra, rb, rc, busy, step};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL brake_right c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
  endtask

  task automatic test_hazard_preempt();
    push_seg(6'b100000, 1'b1, 4, 1'b1);
    push_seg(6'b110000, 1'b1, 3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      push_seg(6'b111111, 1'b1, 4, 1'b1);
      push_seg(6'b000000, 1'b1, 4, 1'b1);
    end
    push_seg(6'b000000, 1'b0, 1, 1'b0);
    for (int c = 0; c < 32; c++) begin
      applyStimulus(c == 0, 1'b0, (c >= 7 && c <= 23), 1'b0, 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la, lb, lc, ra, rb, rc, busy, step};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL hazard_preempt c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
  endtask

  task automatic test_both_turns();
    for (int k = 0; k < 2; k++) begin
      push_seg(6'b111111, 1'b1, 4, 1'b1);
      push_seg(6'b000000, 1'b1, 4, 1'b1);
      push_seg(6'b000000, 1'b0, 1, 1'b0);
    end
    for (int c = 0; c < 18; c++) begin
      applyStimulus((c <= 9), (c <= 9), 1'b0, (c >= 3 && c <= 7), 1'b0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la, lb, lc, ra, rb, rc, busy, step};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL both_turns c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    push_seg(6'b000100, 1'b1, 4, 1'b1);
    push_seg(6'b000110, 1'b1, 1, 1'b0);
    push_seg(6'b000000, 1'b0, 1, 1'b0);
    push_seg(6'b000100, 1'b1, 4, 1'b1);
    push_seg(6'b000110, 1'b1, 4, 1'b1);
    push_seg(6'b000111, 1'b1, 4, 1'b1);
    push_seg(6'b000000, 1'b0, 1, 1'b0);
    for (int c = 0; c < 19; c++) begin
      applyStimulus(1'b0, (c == 0 || c == 5 || c == 6), 1'b0, 1'b0, (c == 5));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la, lb, lc, ra, rb, rc, busy, step};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL reset_mid c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
  endtask

  task automatic test_tick_div1();
    for (int k = 0; k < 2; k++) begin
      push_seg(6'b100000, 1'b1, 1, 1'b1);
      push_seg(6'b110000, 1'b1, 1, 1'b1);
      push_seg(6'b111000, 1'b1, 1, 1'b1);
      push_seg(6'b000000, 1'b0, 1, 1'b0);
    end
    for (int c = 0; c < 8; c++) begin
      left1 = 1'b1;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {la1, lb1, lc1, ra1, rb1, rc1, busy1, step1};
      checks++;
      if (obs !== {e.lamps, e.busy, e.step})
        $display("[TB] FAIL tick_div1 c%0d: got %b want %b", c, obs, {e.lamps, e.busy, e.step});
      else passed++;
    end
    left1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_left_pulse();
    test_brake_right();
    test_hazard_preempt();
    test_both_turns();
    test_reset_mid();
    test_tick_div1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Sequencing controller for the rear-lamp cluster: arbitrates the driver's left, right, hazard and brake requests. It paces the three-step turn sweep with an internal step prescaler and drives the six lamp outputs (la, lb, lc on the left; ra, rb, rc on the right) as registered signals. It sits between the switch/debounce logic and the lamp drivers and replaces free-running per-clock sequencing with a timed, prioritised schedule.

## Interface
- TICK_DIV, 4, clock cycles per lamp step; legal range 1..255
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset; one clock, sampled on rising edge of clk
- left_req  in  1  left turn request (level)
- right_req  in  1  right turn request (level)
- hazard_req  in  1  hazard request (level), highest priority
- brake  in  1  brake pedal (level), overlay only
- la, lb, lc  out  1 each  left lamps, registered
- ra, rb, rc  out  1 each  right lamps, registered
- busy  out  1  high whenever state is not IDLE (combinational from state)
- step  out  1  one-cycle pulse on each prescaler tick (combinational)

## Operation
- States: IDLE, L1, L2, L3, R1, R2, R3, HZ_ON, HZ_OFF.
- Prescaler: 8-bit cnt, runs 0..TICK_DIV-1 while state is not IDLE; tick = (state is not IDLE) and (cnt == TICK_DIV-1); cnt wraps to 0 on tick; cnt cleared to 0 on every state entry from IDLE and on every hazard preemption. cnt held at 0 in IDLE.
- IDLE arbitration, evaluated every cycle (no tick needed), in priority order:
  - hazard_req, or (left_req and right_req) -> HZ_ON
  - left_req -> L1
  - right_req -> R1
  - else stay IDLE
- Turn sweep, advances on tick only: L1->L2->L3->IDLE; R1->R2->R3->IDLE. left_req/right_req changes are ignored mid-sweep.
- Hazard preemption: hazard_req high in any L*/R* state -> HZ_ON on the next edge, regardless of tick. cnt is cleared.
- Hazard blink: HZ_ON->HZ_OFF on tick; HZ_OFF->HZ_ON on tick if hazard_req, else IDLE. Release of hazard_req in HZ_ON takes effect only after the following HZ_OFF completes.
- Lamp pattern {la,lb,lc,ra,rb,rc} by state: IDLE 000000, L1 100000, L2 110000, L3 111000, R1 000100, R2 000110, R3 000111, HZ_ON 111111, HZ_OFF 000000.
- Brake overlay: in IDLE, all six lamps on. In L* states, ra/rb/rc forced on. In R* states, la/lb/lc forced on. In HZ_* states, brake is ignored.
- Lamp registers load pattern(next_state, brake) each edge, so lamps always match the current state and the brake level sampled at the same edge.

## Timing
- Reset: state IDLE, cnt 0, all six lamps 0; busy 0, step 0. Reset mid-sequence aborts immediately at that edge. The first edge after reset release evaluates IDLE arbitration normally.
- Request latency: a request sampled at edge N puts the block in L1/R1/HZ_ON after edge N, with lamps valid in the same cycle.
- Each sweep/blink state lasts exactly TICK_DIV cycles. The full turn sweep is 3*TICK_DIV cycles followed by at least 1 IDLE cycle. A held left_req repeats with period 3*TICK_DIV+1.
- TICK_DIV=1: tick every non-IDLE cycle; sweep is 3 cycles.
- Brake changes appear on lamps one edge after being sampled. Brake never alters state or cnt.
- Simultaneous left_req+right_req in IDLE is treated as hazard, for as long as the HZ_OFF exit check sees hazard_req only. Lamps return to IDLE when hazard_req is low, even if both turns are still high.

## Test plan
- Reset then left_req pulse (1 cycle), TICK_DIV=4 -> lamps 100000 for 4 cycles, 110000 for 4, 111000 for 4, then 000000; busy high exactly 12 cycles; step pulses 3 times.
- Held right_req with brake=1 -> IDLE 111111; R1 111100, R2 111110, R3 111111 for 4 cycles each; 1 IDLE cycle at 111111; R1 restarts on cycle 13 after entry.
- Left sweep in L2, cnt=2, hazard_req asserted -> HZ_ON (111111) next edge; 4 cycles on, 4 off, repeating. Drop hazard_req during HZ_ON -> completes HZ_OFF, then IDLE.
- left_req and right_req asserted in same cycle from IDLE -> HZ_ON; brake=1 during HZ_OFF -> lamps stay 000000.
- Assert reset in R2 -> lamps 000000 and busy 0 after that edge. Release with right_req high -> R1 one edge after release.
- TICK_DIV=1 build, left_req held -> 100000, 110000, 111000, 000000 on consecutive cycles, repeating with period 4.
